// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU fetch port, the CPU load/store port and the single-port memory
// interface that the arbiter sits between.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_wack;
   logic        d_misalign;

   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wren;
   logic        mem_rren;
   logic        mem_E;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ready, if_rvalid, if_rdata,
      output d_ready, d_rvalid, d_rdata, d_wack, d_misalign,
      output mem_addr, mem_wdata, mem_wren, mem_rren, mem_E
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ready, if_rvalid, if_rdata,
      input  d_ready, d_rvalid, d_rdata, d_wack, d_misalign,
      input  mem_addr, mem_wdata, mem_wren, mem_rren, mem_E
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges fetch and load/store requests onto one single-port word memory, data side
// first, with a streak limit that forces a fetch grant. Reads return after one cycle.
//
// state | meaning
// IDLE  | no read response due this cycle
// RD_IF | memory read data this cycle belongs to the fetch side
// RD_D  | memory read data this cycle belongs to the load/store side
module mem_port_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_D_STREAK + 1);

   typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] streak, streak_nxt;
   logic [29:0]   addr_q, addr_nxt;
   logic [31:0]   if_rdata_q, d_rdata_q;
   logic          wack_q, wack_nxt;
   logic          misalign_q, misalign_nxt;
   logic          force_if, grant_d, grant_if, d_aligned;
   logic          wren, rren;
   logic          unused_if_lsb;

   assign unused_if_lsb = ^bus.if_addr[1:0];

   always_comb begin
      force_if  = bus.if_req && (streak == SW'(MAX_D_STREAK));
      grant_d   = bus.d_req && !force_if && !rst;
      grant_if  = bus.if_req && !grant_d && !rst;
      d_aligned = (bus.d_addr[1:0] == 2'b00);
   end

   always_comb begin
      state_nxt    = IDLE;
      streak_nxt   = streak;
      addr_nxt     = addr_q;
      wack_nxt     = 1'b0;
      misalign_nxt = 1'b0;
      wren         = 1'b0;
      rren         = 1'b0;

      if (grant_if) begin
         addr_nxt  = bus.if_addr[31:2];
         rren      = 1'b1;
         state_nxt = RD_IF;
      end else if (grant_d) begin
         if (d_aligned) begin
            addr_nxt = bus.d_addr[31:2];
            if (bus.d_we) begin
               wren     = 1'b1;
               wack_nxt = 1'b1;
            end else begin
               rren      = 1'b1;
               state_nxt = RD_D;
            end
         end else begin
            misalign_nxt = 1'b1;
         end
      end

      // Misaligned data grants still count toward the streak: they occupy the slot.
      if (!bus.if_req || grant_if) begin
         streak_nxt = '0;
      end else if (grant_d && (streak != SW'(MAX_D_STREAK))) begin
         streak_nxt = streak + SW'(1);
      end
   end

   always_comb begin
      bus.if_ready   = grant_if;
      bus.d_ready    = grant_d;
      bus.mem_wren   = wren;
      bus.mem_rren   = rren;
      bus.mem_E      = wren || rren;
      bus.mem_addr   = rst ? 30'd0 : addr_nxt;
      bus.mem_wdata  = rst ? 32'd0 : bus.d_wdata;
      bus.if_rvalid  = (state == RD_IF) && !rst;
      bus.d_rvalid   = (state == RD_D) && !rst;
      bus.d_wack     = wack_q && !rst;
      bus.d_misalign = misalign_q && !rst;
      bus.if_rdata   = if_rdata_q;
      bus.d_rdata    = d_rdata_q;
      if (rst) begin
         bus.if_rdata = 32'd0;
         bus.d_rdata  = 32'd0;
      end else if (state == RD_IF) begin
         bus.if_rdata = bus.mem_rdata;
      end else if (state == RD_D) begin
         bus.d_rdata = bus.mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         streak     <= '0;
         addr_q     <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         wack_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         streak     <= streak_nxt;
         addr_q     <= addr_nxt;
         wack_q     <= wack_nxt;
         misalign_q <= misalign_nxt;
         if (state == RD_IF) begin
            if_rdata_q <= bus.mem_rdata;
         end
         if (state == RD_D) begin
            d_rdata_q <= bus.mem_rdata;
         end
      end
   end
endmodule
